// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcodes, datapath control codes and the funct3 -> ALU helper.
package mc_ctrl_pkg;

   // FSM state encodings; the values are visible on the state port.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   // Supported opcodes.
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_XOR = 3'b011,
      ALU_SRL = 3'b101,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_sel_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } mem_to_reg_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_JAL, CLS_ILL
   } inst_class_t;

   // Every control output the FSM drives, bundled so reset can zero them at once.
   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic        mem_sel_data;
      logic        ir_we;
      logic        pc_we;
      logic        alu_src_b;
      logic        jump;
      logic        branch;
      logic        reg_write;
      mem_to_reg_t mem_to_reg;
      alu_ctrl_t   alu_ctrl;
      imm_sel_t    imm_sel;
   } ctrl_t;

   // funct3 values shared by the R and I-ALU groups that we implement.
   function automatic logic f3_alu_ok(input logic [2:0] f3);
      return f3 inside {3'b000, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
   endfunction

   function automatic alu_ctrl_t f3_to_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b010:  return ALU_SLT;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: classifies the instruction word and
// produces its ALU operation and immediate format.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [31:0] inst,
   output inst_class_t inst_class,
   output alu_ctrl_t   alu_ctrl,
   output imm_sel_t    imm_sel,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Register and immediate fields are the datapath's business, not ours.
   logic unused_fields;
   assign unused_fields = ^{inst[24:15], inst[11:7]};

   // Class, ALU operation and immediate format from opcode/funct fields.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      inst_class = CLS_ILL;
      alu_ctrl   = ALU_AND;
      imm_sel    = IMM_I;
      case (opcode)
         OP_R: begin
            if (funct7 == F7_ZERO && f3_alu_ok(funct3)) begin
               inst_class = CLS_R;
               alu_ctrl   = f3_to_alu(funct3);
            end else if (funct7 == F7_SUB && funct3 == 3'b000) begin
               inst_class = CLS_R;
               alu_ctrl   = ALU_SUB;
            end
         end
         OP_I: begin
            // Shift-right is only legal as the logical form (funct7 clear).
            if (f3_alu_ok(funct3) && (funct3 != 3'b101 || funct7 == F7_ZERO)) begin
               inst_class = CLS_I;
               alu_ctrl   = f3_to_alu(funct3);
            end
         end
         OP_LW: begin
            inst_class = CLS_LW;
            alu_ctrl   = ALU_ADD;
         end
         OP_SW: begin
            inst_class = CLS_SW;
            alu_ctrl   = ALU_ADD;
            imm_sel    = IMM_S;
         end
         OP_BEQ: begin
            inst_class = CLS_BEQ;
            alu_ctrl   = ALU_SUB;
            imm_sel    = IMM_B;
         end
         OP_JAL: begin
            inst_class = CLS_JAL;
            imm_sel    = IMM_J;
         end
         default: ;
      endcase
   end

   assign illegal = (inst_class == CLS_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32 subset controller: FSM, memory-wait timeout and sticky
// error/halt flags. Define MC_CTRL_ILLEGAL_TRAP_EN to halt on illegal
// instructions; otherwise they retire as NOPs.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel_data,
   output logic        ir_we,
   output logic        pc_we,
   output logic        ALUSrc_B,
   output logic        Jump,
   output logic        Branch,
   output logic        RegWrite,
   output logic [1:0]  MemtoReg,
   output logic [2:0]  ALU_Control,
   output logic [1:0]  ImmSel,
   output logic [2:0]  state,
   output logic        bus_err,
   output logic        halted
);

   localparam int CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
   // Counter value seen during the last cycle we are willing to wait.
   localparam logic [CW-1:0] LAST = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          bus_err_q, bus_err_d;
   logic          halted_q, halted_d;
   ctrl_t         ctrl, ctrl_out;
   logic          timeout;
   logic          exec_src_b;

   inst_class_t   dec_class;
   alu_ctrl_t     dec_alu;
   imm_sel_t      dec_imm;
   logic          dec_illegal;

   mc_ctrl_decode u_decode (
      .inst       (inst),
      .inst_class (dec_class),
      .alu_ctrl   (dec_alu),
      .imm_sel    (dec_imm),
      .illegal    (dec_illegal)
   );

   // Second ALU operand is the immediate for I-ALU, loads and stores.
   assign exec_src_b = (dec_class == CLS_I) || (dec_class == CLS_LW) || (dec_class == CLS_SW);

   // An un-acked cycle at the limit ends the wait; an ack in that cycle still wins.
   assign timeout = (WAIT_LIMIT != 0) && !mem_ack && (wait_q == LAST);

   // Next-state and control outputs for the current state.
   always_comb begin
      ctrl      = '0;
      state_d   = state_q;
      bus_err_d = bus_err_q;
      halted_d  = halted_q;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_req = 1'b1;
            if (mem_ack) begin
               ctrl.ir_we = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               halted_d  = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_DECODE: begin
            if (dec_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               halted_d = 1'b1;
               state_d  = S_HALT;
`else
               ctrl.pc_we = 1'b1;
               state_d    = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            ctrl.alu_ctrl  = dec_alu;
            ctrl.imm_sel   = dec_imm;
            ctrl.alu_src_b = exec_src_b;
            case (dec_class)
               CLS_R, CLS_I:   state_d = S_WB;
               CLS_LW, CLS_SW: state_d = S_MEM;
               CLS_BEQ: begin
                  ctrl.branch = 1'b1;
                  ctrl.pc_we  = 1'b1;
                  state_d     = S_FETCH;
               end
               CLS_JAL: begin
                  ctrl.jump       = 1'b1;
                  ctrl.reg_write  = 1'b1;
                  ctrl.mem_to_reg = WB_PC4;
                  ctrl.pc_we      = 1'b1;
                  state_d         = S_FETCH;
               end
               // inst is held stable, so an illegal word never gets here.
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            ctrl.alu_ctrl     = dec_alu;
            ctrl.imm_sel      = dec_imm;
            ctrl.alu_src_b    = exec_src_b;
            ctrl.mem_req      = 1'b1;
            ctrl.mem_sel_data = 1'b1;
            ctrl.mem_we       = (dec_class == CLS_SW);
            if (mem_ack) begin
               ctrl.pc_we = 1'b1;
               if (dec_class == CLS_LW) begin
                  ctrl.reg_write  = 1'b1;
                  ctrl.mem_to_reg = WB_MEM;
               end
               state_d = S_FETCH;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               halted_d  = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            ctrl.alu_ctrl  = dec_alu;
            ctrl.imm_sel   = dec_imm;
            ctrl.alu_src_b = exec_src_b;
            ctrl.reg_write = 1'b1;
            ctrl.pc_we     = 1'b1;
            state_d        = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // Wait counter: zero on entry to a waiting state, counts while we stay there.
   always_comb begin
      wait_d = '0;
      if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM)) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + CW'(1);
      end
   end

   // State, wait counter and sticky flags.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
         halted_q  <= halted_d;
      end
   end

   // NOTE: reset gates the outputs combinationally so a coincident mem_ack can
   // never leak a pc_we/RegWrite while rst is high.
   assign ctrl_out = rst ? '0 : ctrl;

   assign mem_req      = ctrl_out.mem_req;
   assign mem_we       = ctrl_out.mem_we;
   assign mem_sel_data = ctrl_out.mem_sel_data;
   assign ir_we        = ctrl_out.ir_we;
   assign pc_we        = ctrl_out.pc_we;
   assign ALUSrc_B     = ctrl_out.alu_src_b;
   assign Jump         = ctrl_out.jump;
   assign Branch       = ctrl_out.branch;
   assign RegWrite     = ctrl_out.reg_write;
   assign MemtoReg     = ctrl_out.mem_to_reg;
   assign ALU_Control  = ctrl_out.alu_ctrl;
   assign ImmSel       = ctrl_out.imm_sel;
   assign state        = rst ? 3'd0 : 3'(state_q);
   assign bus_err      = rst ? 1'b0 : bus_err_q;
   assign halted       = rst ? 1'b0 : halted_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl (WAIT_LIMIT=4). Expected per-cycle output
// vectors are composed from instruction-level rules; a negedge process
// compares every driven cycle.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ack = 1'b0;
   logic [31:0] inst = 32'h0;

   logic mem_req, mem_we, mem_sel_data, ir_we, pc_we;
   logic ALUSrc_B, Jump, Branch, RegWrite;
   logic [1:0] MemtoReg, ImmSel;
   logic [2:0] ALU_Control, state;
   logic bus_err, halted;

   mc_ctrl #(.WAIT_LIMIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst         (inst),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_sel_data (mem_sel_data),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .ALUSrc_B     (ALUSrc_B),
      .Jump         (Jump),
      .Branch       (Branch),
      .RegWrite     (RegWrite),
      .MemtoReg     (MemtoReg),
      .ALU_Control  (ALU_Control),
      .ImmSel       (ImmSel),
      .state        (state),
      .bus_err      (bus_err),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       berr, hlt, req, we, sel, irw, pcw, srcb, jmp, br, rw;
      logic [1:0] m2r;
      logic [2:0] alu;
      logic [1:0] imm;
   } vec_t;

   typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_t;

   vec_t  act, exp_v;
   logic  exp_on = 1'b0;
   string phase = "";
   int    n_cmp = 0, n_bad = 0;
   int    pc_we_cnt = 0, run_len = 0, last_len = 0;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   localparam int RETIRED_EXP = 18;
`else
   localparam int RETIRED_EXP = 23;
`endif

   always_comb begin
      act      = '0;
      act.st   = state;
      act.berr = bus_err;
      act.hlt  = halted;
      act.req  = mem_req;
      act.we   = mem_we;
      act.sel  = mem_sel_data;
      act.irw  = ir_we;
      act.pcw  = pc_we;
      act.srcb = ALUSrc_B;
      act.jmp  = Jump;
      act.br   = Branch;
      act.rw   = RegWrite;
      act.m2r  = MemtoReg;
      act.alu  = ALU_Control;
      act.imm  = ImmSel;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison plus retire bookkeeping (cycles per instruction, pc_we pulses).
   always @(negedge clk) begin
      if (exp_on) check(phase, 32'(act), 32'(exp_v));
      if (rst) begin
         run_len = 0;
      end else begin
         run_len++;
         if (pc_we) begin
            pc_we_cnt++;
            last_len = run_len;
            run_len  = 0;
         end
      end
   end

   task automatic step(input logic r, input logic a, input vec_t e, input string ph);
      rst     = r;
      mem_ack = a;
      exp_v   = e;
      phase   = ph;
      exp_on  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t fetch_vec(input logic ack);
      vec_t v;
      v     = '0;
      v.req = 1'b1;
      v.irw = ack;
      return v;
   endfunction

   // Drive one instruction from FETCH to retirement, building each cycle's expectation.
   task automatic run_instr(input logic [31:0] word, input kind_t k, input logic [2:0] alu,
                            input int fw, input int mw, input string nm);
      vec_t e, x;
      inst = word;
      for (int i = 0; i < fw; i++) step(1'b0, 1'b0, fetch_vec(1'b0), {nm, " fetch-wait"});
      step(1'b0, 1'b1, fetch_vec(1'b1), {nm, " fetch"});
      e    = '0;
      e.st = 3'd1;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      if (k == K_ILL) e.pcw = 1'b1;
`endif
      step(1'b0, 1'b0, e, {nm, " decode"});
      if (k == K_ILL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         e     = '0;
         e.st  = 3'd7;
         e.hlt = 1'b1;
         step(1'b0, 1'b1, e, {nm, " halt"});
         step(1'b0, 1'b0, e, {nm, " halt hold"});
         step(1'b1, 1'b0, '0, {nm, " reset"});
`endif
         return;
      end
      x      = '0;
      x.alu  = alu;
      x.srcb = (k == K_I || k == K_LW || k == K_SW);
      x.imm  = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
      x.br   = (k == K_BEQ);
      x.jmp  = (k == K_JAL);
      e      = x;
      e.st   = 3'd2;
      if (k == K_BEQ || k == K_JAL) e.pcw = 1'b1;
      if (k == K_JAL) begin
         e.rw  = 1'b1;
         e.m2r = 2'b10;
      end
      step(1'b0, 1'b0, e, {nm, " exec"});
      if (k == K_R || k == K_I) begin
         e     = x;
         e.st  = 3'd4;
         e.rw  = 1'b1;
         e.pcw = 1'b1;
         step(1'b0, 1'b0, e, {nm, " wb"});
      end
      if (k == K_LW || k == K_SW) begin
         e     = x;
         e.st  = 3'd3;
         e.req = 1'b1;
         e.sel = 1'b1;
         e.we  = (k == K_SW);
         for (int i = 0; i < mw; i++) step(1'b0, 1'b0, e, {nm, " mem-wait"});
         e.pcw = 1'b1;
         if (k == K_LW) begin
            e.rw  = 1'b1;
            e.m2r = 2'b01;
         end
         step(1'b0, 1'b1, e, {nm, " mem-ack"});
      end
   endtask

   initial begin
      vec_t e;
      rst = 1'b1;
      @(posedge clk);
      #1;
      // Reset: all outputs zero even with mem_ack high.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0, "reset");

      run_instr(32'h002081B3, K_R, 3'b010, 0, 0, "add");
      check("add cycles", 32'(last_len), 32'd4);
      run_instr(32'h402081B3, K_R, 3'b110, 1, 0, "sub");
      run_instr(32'h0020A1B3, K_R, 3'b111, 0, 0, "slt");
      run_instr(32'h0020C1B3, K_R, 3'b100 - 3'b001, 0, 0, "xor");
      run_instr(32'h0020D1B3, K_R, 3'b101, 0, 0, "srl");
      run_instr(32'h0020E1B3, K_R, 3'b001, 0, 0, "or");
      run_instr(32'h0020F1B3, K_R, 3'b000, 0, 0, "and");
      run_instr(32'h00500093, K_I, 3'b010, 0, 0, "addi");
      run_instr(32'hFFF00093, K_I, 3'b010, 0, 0, "addi-neg");
      run_instr(32'h0050A093, K_I, 3'b111, 0, 0, "slti");
      run_instr(32'h0050C093, K_I, 3'b011, 0, 0, "xori");
      run_instr(32'h0050E093, K_I, 3'b001, 0, 0, "ori");
      run_instr(32'h0050F093, K_I, 3'b000, 0, 0, "andi");
      run_instr(32'h0020D093, K_I, 3'b101, 0, 0, "srli");
      // lw acked in the 4th MEM cycle: the last cycle before timeout still succeeds.
      run_instr(32'h0080A283, K_LW, 3'b010, 0, 3, "lw");
      check("lw cycles", 32'(last_len), 32'd7);
      // sw whose fetch is acked in the 4th FETCH cycle.
      run_instr(32'h0050A423, K_SW, 3'b010, 3, 0, "sw");
      check("sw cycles", 32'(last_len), 32'd7);
      run_instr(32'h00208463, K_BEQ, 3'b110, 0, 0, "beq");
      check("beq cycles", 32'(last_len), 32'd3);
      run_instr(32'h010000EF, K_JAL, 3'b000, 0, 0, "jal");
      check("jal cycles", 32'(last_len), 32'd3);

      run_instr(32'h002091B3, K_ILL, 3'b000, 0, 0, "ill-sll");
      run_instr(32'h4020D1B3, K_ILL, 3'b000, 0, 0, "ill-sra");
      run_instr(32'h00209093, K_ILL, 3'b000, 0, 0, "ill-slli");
      run_instr(32'h4020D093, K_ILL, 3'b000, 0, 0, "ill-srai");
      run_instr(32'h0000007F, K_ILL, 3'b000, 0, 0, "ill-7f");

      // Reset during MEM with a coincident ack: no retire, outputs zero.
      inst = 32'h0080A283;
      step(1'b0, 1'b1, fetch_vec(1'b1), "rst-mem fetch");
      e = '0; e.st = 3'd1;
      step(1'b0, 1'b0, e, "rst-mem decode");
      e = '0; e.st = 3'd2; e.srcb = 1'b1; e.alu = 3'b010;
      step(1'b0, 1'b0, e, "rst-mem exec");
      e.st = 3'd3; e.req = 1'b1; e.sel = 1'b1;
      step(1'b0, 1'b0, e, "rst-mem wait");
      step(1'b1, 1'b1, '0, "rst-mem ack");
      check("retired", 32'(pc_we_cnt), RETIRED_EXP);

      // Timeout: four un-acked FETCH cycles (first one right after release), then HALT.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, fetch_vec(1'b0), "timeout fetch");
      e = '0; e.st = 3'd7; e.berr = 1'b1; e.hlt = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, e, "timeout halt");
      check("halt state", 32'(state), 32'd7);
      check("halt bus_err", 32'(bus_err), 32'd1);
      check("halt mem_req", 32'(mem_req), 32'd0);
      step(1'b1, 1'b1, '0, "halt reset");
      step(1'b0, 1'b1, fetch_vec(1'b1), "recover fetch");
      check("retired final", 32'(pc_we_cnt), RETIRED_EXP);
      exp_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
